// File: rtl/prbs_checker_lfsr.sv
// ---------------------------------------------------------------------------
// prbs_checker_lfsr
//
// Receive-side PRBS checker for the DAC data path. Self-synchronises a local
// history register to the incoming serial stream, declares lock after a run
// of correct predictions, then free-runs and counts bit errors.
//
// Ports
//   dac_clk             in   clock, rising edge
//   reset_n             in   synchronous, active-low reset
//   bit_valid           in   qualifies prbs_bit_in
//   prbs_bit_in         in   received serial bit
//   prbs_pn_select_reg  in   [4:0] 0=PN3 .. 14=PN31, 15..31 unsupported
//   clear_cnt           in   synchronous clear of err_count (wins over +1)
//   locked              out  checker aligned
//   bit_err             out  one-cycle pulse per mismatched bit while locked
//   err_count           out  [ERR_W-1:0] accumulated error count
//   lfsr_state          out  [32:0] history register, h[0] = newest bit
//
// Build option
//   PRBS_CHK_ERR_SAT_EN  defined: err_count saturates at all-ones.
//                        undefined: err_count wraps.
// ---------------------------------------------------------------------------
module prbs_checker_lfsr #(
    parameter int LOCK_MATCH = 64,
    parameter int WINDOW     = 256,
    parameter int LOSS_ERRS  = 8,
    parameter int ERR_W      = 32
) (
    input  logic             dac_clk,
    input  logic             reset_n,
    input  logic             bit_valid,
    input  logic             prbs_bit_in,
    input  logic [4:0]       prbs_pn_select_reg,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_count,
    output logic [32:0]      lfsr_state
);

    // Counters run 0..limit-1; the limit itself is detected on the last step.
    localparam int MATCH_W = (LOCK_MATCH > 1) ? $clog2(LOCK_MATCH) : 1;
    localparam int WIN_W   = (WINDOW     > 1) ? $clog2(WINDOW)     : 1;
    localparam int LERR_W  = (LOSS_ERRS  > 1) ? $clog2(LOSS_ERRS)  : 1;

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCH - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [LERR_W-1:0]  LERR_LAST  = LERR_W'(LOSS_ERRS - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // One-hot bit at history position t-1 for polynomial tap t.
    function automatic logic [32:0] tap_bit(input int t);
        return 33'd1 << (t - 1);
    endfunction

    // Tap mask over the history register; zero for unsupported selects.
    function automatic logic [32:0] tap_mask(input logic [4:0] sel);
        logic [32:0] m;
        m = '0;
        case (sel)
            5'd0:  m = tap_bit(3)  | tap_bit(2);
            5'd1:  m = tap_bit(5)  | tap_bit(3);
            5'd2:  m = tap_bit(7)  | tap_bit(6);
            5'd3:  m = tap_bit(9)  | tap_bit(5);
            5'd4:  m = tap_bit(11) | tap_bit(9);
            5'd5:  m = tap_bit(13) | tap_bit(12) | tap_bit(2)  | tap_bit(1);
            5'd6:  m = tap_bit(15) | tap_bit(14);
            5'd7:  m = tap_bit(17) | tap_bit(14);
            5'd8:  m = tap_bit(19) | tap_bit(18) | tap_bit(17) | tap_bit(14);
            5'd9:  m = tap_bit(21) | tap_bit(19);
            5'd10: m = tap_bit(23) | tap_bit(18);
            5'd11: m = tap_bit(25) | tap_bit(22);
            5'd12: m = tap_bit(27) | tap_bit(26) | tap_bit(25) | tap_bit(22);
            5'd13: m = tap_bit(29) | tap_bit(27);
            5'd14: m = tap_bit(31) | tap_bit(28);
            default: m = '0;
        endcase
        return m;
    endfunction

    state_t             state_q,    state_d;
    logic [32:0]        h_q,        h_d;
    logic [5:0]         fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q,  win_cnt_d;
    logic [LERR_W-1:0]  win_errs_q, win_errs_d;
    logic [4:0]         sel_q,      sel_d;
    logic               locked_q,   locked_d;
    logic               bit_err_q,  bit_err_d;
    logic [ERR_W-1:0]   err_cnt_q,  err_cnt_d;

    logic       predicted;
    logic       mismatch;
    logic       sel_changed;
    logic       sel_bad;
    logic       err_inc;
    logic [5:0] fill_last;

    // PN order N = 2*sel + 3, so the last fill index is 2*sel + 2.
    assign fill_last   = {prbs_pn_select_reg, 1'b0} + 6'd2;
    assign predicted   = ^(h_q & tap_mask(prbs_pn_select_reg));
    assign mismatch    = prbs_bit_in ^ predicted;
    assign sel_changed = (prbs_pn_select_reg != sel_q);
    assign sel_bad     = (prbs_pn_select_reg > 5'd14);

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_errs_d  = win_errs_q;
        locked_d    = locked_q;
        bit_err_d   = 1'b0;
        err_inc     = 1'b0;
        sel_d       = prbs_pn_select_reg;

        if (sel_changed || sel_bad) begin
            // A new polynomial invalidates everything learned so far; the
            // bit arriving with the change is discarded.
            state_d     = ST_FILL;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_errs_d  = '0;
            locked_d    = 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                ST_FILL: begin
                    h_d = {h_q[31:0], prbs_bit_in};
                    if (fill_cnt_q == fill_last) begin
                        state_d     = ST_SEARCH;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 6'd1;
                    end
                end

                ST_SEARCH: begin
                    // Received bit always enters the history so a wrong
                    // guess flushes out after N bits.
                    h_d = {h_q[31:0], prbs_bit_in};
                    if (mismatch) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MATCH_LAST) begin
                        state_d     = ST_LOCKED;
                        locked_d    = 1'b1;
                        match_cnt_d = '0;
                        win_cnt_d   = '0;
                        win_errs_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    // Free-run on our own prediction so a line error is
                    // counted once rather than once per tap.
                    h_d       = {h_q[31:0], predicted};
                    bit_err_d = mismatch;
                    err_inc   = mismatch;
                    if (mismatch && (win_errs_q == LERR_LAST)) begin
                        state_d    = ST_FILL;
                        locked_d   = 1'b0;
                        fill_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_errs_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d  = '0;
                        win_errs_d = '0;
                    end else begin
                        win_cnt_d  = win_cnt_q + 1'b1;
                        win_errs_d = win_errs_q + LERR_W'(mismatch);
                    end
                end

                default: begin
                    state_d  = ST_FILL;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clear has priority over a coincident error.
        err_cnt_d = err_cnt_q;
        if (clear_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc) begin
`ifdef PRBS_CHK_ERR_SAT_EN
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
`else
            err_cnt_d = err_cnt_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge dac_clk) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            h_q         <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_errs_q  <= '0;
            // Track the select through reset so release is not seen as a change.
            sel_q       <= sel_d;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_errs_q  <= win_errs_d;
            sel_q       <= sel_d;
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked     = locked_q;
    assign bit_err    = bit_err_q;
    assign err_count  = err_cnt_q;
    assign lfsr_state = h_q;

endmodule

// File: tb/tb_prbs_checker_lfsr.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker_lfsr
//
// Drives PRBS streams from a bench-side generator (random seed, random gaps,
// injected bit flips) into prbs_checker_lfsr built with ERR_W=4, and compares
// every cycle against a bit-list reference model plus directed scenario
// checks (lock latency, single error, loss/relock, select change, counter
// limit, clear priority, reset while locked).
// ---------------------------------------------------------------------------
module tb_prbs_checker_lfsr;

    localparam int ERR_W   = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef PRBS_CHK_ERR_SAT_EN
    localparam int EXP_LIM = 15;
`else
    localparam int EXP_LIM = 4;
`endif

    logic             dac_clk = 1'b0;
    logic             reset_n;
    logic             bit_valid;
    logic             prbs_bit_in;
    logic [4:0]       prbs_pn_select_reg;
    logic             clear_cnt;
    logic             locked;
    logic             bit_err;
    logic [ERR_W-1:0] err_count;
    logic [32:0]      lfsr_state;

    always #5 dac_clk = ~dac_clk;

    prbs_checker_lfsr #(
        .LOCK_MATCH(64),
        .WINDOW    (256),
        .LOSS_ERRS (8),
        .ERR_W     (ERR_W)
    ) dut (
        .dac_clk           (dac_clk),
        .reset_n           (reset_n),
        .bit_valid         (bit_valid),
        .prbs_bit_in       (prbs_bit_in),
        .prbs_pn_select_reg(prbs_pn_select_reg),
        .clear_cnt         (clear_cnt),
        .locked            (locked),
        .bit_err           (bit_err),
        .err_count         (err_count),
        .lfsr_state        (lfsr_state)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Polynomial taps straight from the PN table; 0 = unused slot.
    int taps [15][4] = '{
        '{3, 2, 0, 0},     '{5, 3, 0, 0},     '{7, 6, 0, 0},
        '{9, 5, 0, 0},     '{11, 9, 0, 0},    '{13, 12, 2, 1},
        '{15, 14, 0, 0},   '{17, 14, 0, 0},   '{19, 18, 17, 14},
        '{21, 19, 0, 0},   '{23, 18, 0, 0},   '{25, 22, 0, 0},
        '{27, 26, 25, 22}, '{29, 27, 0, 0},   '{31, 28, 0, 0}
    };

    // ---------------- stream generator ----------------
    bit g_hist[$];   // [0] = most recently sent bit
    int g_sel;

    task automatic g_new(input int s);
        g_sel = s;
        g_hist.delete();
    endtask

    function automatic bit g_next();
        bit b;
        int n;
        if (g_sel > 14) begin
            b = 1'($urandom_range(0, 1));
        end else begin
            n = 2 * g_sel + 3;
            if (g_hist.size() < n) begin
                b = (g_hist.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                b = 1'b0;
                for (int k = 0; k < 4; k++)
                    if (taps[g_sel][k] != 0) b ^= g_hist[taps[g_sel][k] - 1];
            end
        end
        g_hist.push_front(b);
        if (g_hist.size() > 40) void'(g_hist.pop_back());
        return b;
    endfunction

    // ---------------- reference model ----------------
    bit m_hist[$];   // 33 entries, [0] = newest
    int m_phase;     // 0 filling, 1 searching, 2 locked
    int m_run;       // fill count or match run
    int m_win;
    int m_werr;
    int m_err;
    int m_sel;
    bit m_locked;
    bit m_bit_err;

    function automatic bit m_pred(input int s);
        bit p = 1'b0;
        for (int k = 0; k < 4; k++)
            if (taps[s][k] != 0) p ^= m_hist[taps[s][k] - 1];
        return p;
    endfunction

    task automatic m_push(input bit b);
        m_hist.push_front(b);
        void'(m_hist.pop_back());
    endtask

    task automatic m_step(input bit rst_n, input bit v, input bit b, input int s, input bit clr);
        bit p;
        bit inc = 1'b0;
        if (!rst_n) begin
            m_hist.delete();
            for (int i = 0; i < 33; i++) m_hist.push_back(1'b0);
            m_phase = 0; m_run = 0; m_win = 0; m_werr = 0; m_err = 0;
            m_locked = 1'b0; m_bit_err = 1'b0; m_sel = s;
            return;
        end
        m_bit_err = 1'b0;
        if (s != m_sel || s > 14) begin
            m_phase = 0; m_run = 0; m_locked = 1'b0;
        end else if (v) begin
            p = m_pred(s);
            if (m_phase == 0) begin
                m_push(b);
                m_run++;
                if (m_run == 2 * s + 3) begin m_phase = 1; m_run = 0; end
            end else if (m_phase == 1) begin
                m_push(b);
                m_run = (b == p) ? m_run + 1 : 0;
                if (m_run == 64) begin
                    m_phase = 2; m_run = 0; m_locked = 1'b1; m_win = 0; m_werr = 0;
                end
            end else begin
                m_push(p);
                m_win++;
                if (b != p) begin m_bit_err = 1'b1; inc = 1'b1; m_werr++; end
                if (m_werr == 8) begin
                    m_phase = 0; m_run = 0; m_locked = 1'b0;
                end else if (m_win == 256) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        if (clr) m_err = 0;
        else if (inc) begin
`ifdef PRBS_CHK_ERR_SAT_EN
            if (m_err < ERR_MAX) m_err++;
`else
            m_err = (m_err + 1) % (ERR_MAX + 1);
`endif
        end
        m_sel = s;
    endtask

    // One clock: drive, step model at the edge, compare 1 time unit later.
    task automatic cyc(input bit v, input bit inject);
        bit b;
        logic [32:0] hv;
        b = v ? (g_next() ^ inject) : 1'($urandom_range(0, 1));
        bit_valid   = v;
        prbs_bit_in = b;
        @(posedge dac_clk);
        m_step(reset_n, v, b, int'(prbs_pn_select_reg), clear_cnt);
        #1;
        for (int i = 0; i < 33; i++) hv[i] = m_hist[i];
        chk("model_locked",  64'(locked),     64'(m_locked));
        chk("model_bit_err", 64'(bit_err),    64'(m_bit_err));
        chk("model_err_cnt", 64'(err_count),  64'(m_err));
        chk("model_lfsr",    64'(lfsr_state), 64'(hv));
    endtask

    // Feed a clean stream until lock; check the number of valid bits used.
    task automatic run_to_lock(input string tag, input int exp_bits, input bit rand_valid);
        int nv = 0;
        int guard = 0;
        bit v;
        while (locked !== 1'b1 && guard < 3000) begin
            v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc(v, 1'b0);
            if (v) nv++;
            guard++;
        end
        chk(tag, 64'(nv), 64'(exp_bits));
    endtask

    initial begin
        int seen;
        int ep;
        reset_n            = 1'b0;
        bit_valid          = 1'b0;
        prbs_bit_in        = 1'b0;
        clear_cnt          = 1'b0;
        prbs_pn_select_reg = 5'd1;
        g_new(1);

        // Reset state
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rst_locked",  64'(locked),     64'd0);
        chk("rst_bit_err", 64'(bit_err),    64'd0);
        chk("rst_err_cnt", 64'(err_count),  64'd0);
        chk("rst_lfsr",    64'(lfsr_state), 64'd0);
        reset_n = 1'b1;
        g_new(1);

        // Clean PN5 lock, valid every cycle, 1000 bits total
        run_to_lock("lock_pn5", 69, 1'b0);
        repeat (1000 - 69) cyc(1'b1, 1'b0);
        chk("pn5_clean_err", 64'(err_count), 64'd0);
        chk("pn5_still_locked", 64'(locked), 64'd1);

        // Single error on PN7
        prbs_pn_select_reg = 5'd2; g_new(2);
        cyc(1'b0, 1'b0);
        chk("selchg_unlock_a", 64'(locked), 64'd0);
        run_to_lock("lock_pn7", 71, 1'b1);
        repeat (20) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("single_err_pulse",  64'(bit_err),   64'd1);
        chk("single_err_cnt",    64'(err_count), 64'd1);
        chk("single_err_locked", 64'(locked),    64'd1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, 1'b0);
            if (bit_err) seen++;
        end
        chk("single_err_no_repeat", 64'(seen),      64'd0);
        chk("single_err_cnt_hold",  64'(err_count), 64'd1);

        // Loss of lock on PN9
        prbs_pn_select_reg = 5'd3; g_new(3);
        cyc(1'b0, 1'b0);
        run_to_lock("lock_pn9", 73, 1'b1);
        clear_cnt = 1'b1; cyc(1'b0, 1'b0); clear_cnt = 1'b0;
        chk("clear_idle", 64'(err_count), 64'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (9) cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b1);
            if (i < 7) chk("loss_hold_lock", 64'(locked), 64'd1);
        end
        chk("loss_unlock", 64'(locked),    64'd0);
        chk("loss_err8",   64'(err_count), 64'd8);
        run_to_lock("relock_pn9", 73, 1'b0);
        chk("relock_err_kept", 64'(err_count), 64'd8);

        // Select change while locked, new select arriving on a valid cycle
        prbs_pn_select_reg = 5'd1; g_new(1);
        cyc(1'b0, 1'b0);
        run_to_lock("lock_pn5b", 69, 1'b1);
        repeat (10) cyc(1'b1, 1'b0);
        prbs_pn_select_reg = 5'd3; g_new(3);
        cyc(1'b1, 1'b0);
        chk("selchg_unlock_b", 64'(locked), 64'd0);
        run_to_lock("relock_sel_pn9", 73, 1'b0);

        // Unsupported select never locks
        prbs_pn_select_reg = 5'd20; g_new(20);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0);
            if (locked) seen++;
        end
        chk("sel20_nolock", 64'(seen), 64'd0);

        // Counter limit: 20 errors spaced 40 bits apart (<=7 per window)
        prbs_pn_select_reg = 5'd2; g_new(2);
        cyc(1'b0, 1'b0);
        run_to_lock("lock_pn7b", 71, 1'b0);
        clear_cnt = 1'b1; cyc(1'b1, 1'b0); clear_cnt = 1'b0;
        chk("clear_valid", 64'(err_count), 64'd0);
        for (int i = 0; i < 20; i++) begin
            repeat (39) cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b1);
        end
        chk("cnt_limit",        64'(err_count), 64'(EXP_LIM));
        chk("cnt_limit_locked", 64'(locked),    64'd1);
        clear_cnt = 1'b1; cyc(1'b1, 1'b1); clear_cnt = 1'b0;
        chk("clear_wins",      64'(err_count), 64'd0);
        chk("clear_wins_err",  64'(bit_err),   64'd1);

        // Randomised streams: random PN, gaps and sparse errors
        for (int r = 0; r < 6; r++) begin
            ep = $urandom_range(0, 14);
            prbs_pn_select_reg = 5'(ep); g_new(ep);
            for (int i = 0; i < 600; i++)
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end

        // Reset while locked
        prbs_pn_select_reg = 5'd2; g_new(2);
        cyc(1'b0, 1'b0);
        run_to_lock("lock_pn7c", 71, 1'b0);
        cyc(1'b1, 1'b1);
        chk("pre_rst_err", 64'(bit_err), 64'd1);
        reset_n = 1'b0;
        cyc(1'b1, 1'b0);
        chk("rst_mid_locked",  64'(locked),     64'd0);
        chk("rst_mid_bit_err", 64'(bit_err),    64'd0);
        chk("rst_mid_err_cnt", 64'(err_count),  64'd0);
        chk("rst_mid_lfsr",    64'(lfsr_state), 64'd0);
        reset_n = 1'b1;
        g_new(2);
        run_to_lock("lock_after_rst", 71, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
